// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the program ROM and holds
// the fetched instruction in a valid/ready instruction register for decode.
module fetch_unit #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 8,
  parameter int unsigned PROG_LEN    = 64,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [PC_WIDTH-1:0]    linenumber,
  input  logic [INSTR_WIDTH-1:0] instr,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic [PC_WIDTH-1:0]    ir_pc,
  output logic                   ir_valid,
  input  logic                   ir_ready,
  input  logic                   branch_valid,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   halt,
  output logic                   bad_target,
  output logic [15:0]            fetch_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  // One extra bit so PROG_LEN == 2**PC_WIDTH still compares correctly.
  localparam logic [PC_WIDTH:0]   PROG_LEN_EXT = (PC_WIDTH+1)'(PROG_LEN);
  localparam logic [PC_WIDTH-1:0] LAST_PC      = PC_WIDTH'(PROG_LEN - 1);
  localparam logic [PC_WIDTH-1:0] START_PC     = PC_WIDTH'(RESET_PC);

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic                free;
  logic                fetch;
  logic                target_ok;

  // Slot availability and fetch qualification for the current cycle.
  always_comb begin
    free      = !ir_valid || ir_ready;
    fetch     = (state == RUN) && free && !branch_valid;
    target_ok = {1'b0, branch_target} < PROG_LEN_EXT;
  end

  assign linenumber = pc;

  // Control state, PC, instruction register and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= START_PC;
      ir          <= '0;
      ir_pc       <= '0;
      ir_valid    <= 1'b0;
      bad_target  <= 1'b0;
      fetch_count <= '0;
    end else begin
      // Every state moves to HALTED while halt is high and to RUN otherwise.
      case (state)
        IDLE:    state <= halt ? HALTED : RUN;
        RUN:     state <= halt ? HALTED : RUN;
        HALTED:  state <= halt ? HALTED : RUN;
        default: state <= IDLE;
      endcase

      if (branch_valid) begin
        ir_valid <= 1'b0;
        if (target_ok) begin
          pc <= branch_target;
        end else begin
          pc         <= '0;
          bad_target <= 1'b1;
        end
      end else if (fetch) begin
        ir       <= instr;
        ir_pc    <= pc;
        ir_valid <= 1'b1;
        pc       <= (pc == LAST_PC) ? '0 : pc + 1'b1;
        if (fetch_count != '1) begin
          fetch_count <= fetch_count + 16'd1;
        end
      end else if (ir_valid && ir_ready) begin
        ir_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the cpu2 datapath, directly upstream of the `program` instruction ROM. It owns the program counter and drives the ROM's `linenumber` address. It registers the returned 8-bit instruction into an instruction register, paired with its PC. It hands that register to the decode stage over a valid/ready handshake, and redirects on branch requests (JMP/JNZ) resolved by execute.

## Interface
Parameters:
- `PC_WIDTH`, 8, width of PC and `linenumber`
- `INSTR_WIDTH`, 8, instruction width
- `PROG_LEN`, 64, number of valid program lines; PC wraps modulo this value
- `RESET_PC`, 0, PC value loaded on reset

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk` input 1: single clock; all state updates on its rising edge.
  - `rst` input 1: resets all state immediately, independent of `clk`.
- `linenumber` output PC_WIDTH: ROM address, always equal to the current PC.
- `instr` input INSTR_WIDTH: ROM data for `linenumber`, combinational, same cycle.
- `ir` output INSTR_WIDTH: registered instruction.
- `ir_pc` output PC_WIDTH: address `ir` was fetched from.
- `ir_valid` output 1: `ir`/`ir_pc` hold an unconsumed instruction.
- `ir_ready` input 1: decode accepts `ir` this cycle when `ir_valid && ir_ready`.
- `branch_valid` input 1: redirect request from execute, single-cycle pulse.
- `branch_target` input PC_WIDTH: redirect address.
- `halt` input 1: level; suspends fetching while high.
- `bad_target` output 1: sticky flag; a branch targeted an address >= PROG_LEN.
- `fetch_count` output 16: number of instructions loaded into `ir`, saturating at 16'hFFFF.

## Operation
- States:
  - IDLE: entered on reset.
  - RUN
  - HALTED
- Transitions:
  - IDLE -> RUN unconditionally after one cycle, or -> HALTED if `halt`.
  - RUN -> HALTED when `halt`=1.
  - HALTED -> RUN when `halt`=0.
- Slot free: `free = !ir_valid || ir_ready`.
- Fetch (RUN only, `free`=1, no branch this cycle):
  - `ir <= instr`; `ir_pc <= pc`; `ir_valid <= 1`.
  - `pc <= (pc == PROG_LEN-1) ? 0 : pc+1`.
  - `fetch_count` increments, saturating.
- Stall (RUN, `free`=0): PC, `ir`, `ir_pc`, `ir_valid` all hold. `linenumber` stays stable.
- Consume without refill: if `ir_valid && ir_ready` and no fetch occurs (IDLE, HALTED, or branch), then `ir_valid <= 0`.
- Branch (`branch_valid`=1, any state including IDLE/HALTED) takes priority over fetch:
  - `pc <= branch_target` if `branch_target < PROG_LEN`; otherwise `pc <= 0` and `bad_target <= 1`.
  - `ir_valid <= 0` (flush), even if `ir_ready`=0. The flushed instruction is dropped.
  - No fetch that cycle; `fetch_count` unchanged.
- Branch and `halt` in the same cycle: PC is redirected and state goes to HALTED. Fetching resumes from the target once `halt` falls.
- HALTED: PC frozen. A pending `ir` stays valid until consumed or flushed.
- `bad_target` clears only on reset.

## Timing
- Reset values, applied asynchronously while `rst`=1:
  - `pc`/`linenumber` = RESET_PC.
  - `ir` = 0 (NOP encoding).
  - `ir_pc` = 0.
  - `ir_valid` = 0.
  - `bad_target` = 0.
  - `fetch_count` = 0.
  - State = IDLE.
- Reset asserted mid-run drops any pending `ir` with no handshake.
- First fetch happens on the second rising edge after `rst` deasserts (edge 1: IDLE->RUN; edge 2: load `ir` from RESET_PC).
- With `ir_ready` held high, throughput is one instruction per cycle.
- `ir_pc` lags `linenumber` by one line.
- Branch penalty:
  - Edge with `branch_valid`: PC = target, `ir_valid`=0.
  - Next edge: `ir` = program[target].
  - One bubble cycle in total.
- Outputs `ir`, `ir_pc`, `ir_valid`, `bad_target` and `fetch_count` are registered. `linenumber` is registered (it is the PC).
- No combinational path from any input to any output.

## Test plan
- Reset then free-run, with `ir_ready`=1, ROM preloaded with line values 0..8: `ir_valid` rises 2 cycles after reset release. `ir_pc` then steps 0,1,2,3,... every cycle, and `ir` matches the ROM contents at each `ir_pc`.
- Backpressure: drop `ir_ready` for 3 cycles while `ir_pc`=2. `ir`, `ir_pc`=2 and `linenumber`=3 hold for the 3 cycles. `ir_pc`=3 appears on the first cycle after `ir_ready` returns, with no line skipped or duplicated.
- Branch: pulse `branch_valid` with target=1 while `ir_pc`=8 and `ir_ready`=0. Required: `ir_valid`=0 next cycle, then `ir_pc`=1, `ir`=program[1]. `fetch_count` advances by exactly 1 across the bubble.
- Wrap and bad target:
  - PROG_LEN=64, run to PC=63: next `linenumber`=0.
  - Branch with target=70: PC=0, `bad_target`=1, and `bad_target` stays 1 until reset.
- Halt interactions:
  - Assert `halt` with `ir` valid: `ir` held until `ir_ready`, then `ir_valid`=0 and PC frozen.
  - Branch plus halt in the same cycle to target 4: after `halt` falls, the first `ir_pc` is 4.
- Async reset mid-stall: assert `rst` between clock edges. All outputs take their reset values immediately, without waiting for an edge.
